// File: rtl/ram_sequencer_pkg.sv
// ram_sequencer_pkg: shared state encoding and default RAM geometry for the sequencer
package ram_sequencer_pkg;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH_DEF;
    typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, W_VERIFY, R_EN, R_CAP} state_e;
endpackage

// File: rtl/ram_sequencer_strobe_timer.sv
// ram_strobe_timer: loadable down-counter timing the write-enable strobe width
module ram_strobe_timer
    import ram_sequencer_pkg::*;
#(
    parameter int WE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);
    logic [2:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? 3'(WE_CYCLES - 1) : (en && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign done = cnt_q == 3'd0;
endmodule

// File: rtl/ram_sequencer.sv
// ram_sequencer: arbitrates and phases writes/reads to an active-low RAM with read-back verify
module ram_sequencer
    import ram_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int WE_CYCLES   = 1,
    parameter bit INVERT_READ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic                  prog_valid,
    output logic                  prog_ready,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic [ADDR_WIDTH:0]   prog_count,
    output logic                  verify_err,
    input  logic                  cpu_write,
    input  logic                  cpu_read,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_busy,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we_n,
    output logic                  mem_oe_n,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d, q_true;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  prog_op_q, prog_op_d, rvalid_q, rvalid_d, err_q, err_d, pm_q, strobe_done;

    ram_strobe_timer #(.WE_CYCLES(WE_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == W_SETUP),
        .en   (state_q == W_STROBE),
        .done (strobe_done)
    );

    assign q_true = INVERT_READ ? ~mem_q : mem_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        prog_op_d = prog_op_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        count_d   = count_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (prog_mode) begin
                    if (prog_valid) begin
                        addr_d    = prog_addr;
                        data_d    = prog_data;
                        prog_op_d = 1'b1;
                        state_d   = W_SETUP;
                    end
                end else if (cpu_write) begin
                    addr_d    = cpu_addr;
                    data_d    = cpu_wdata;
                    prog_op_d = 1'b0;
                    state_d   = W_SETUP;
                end else if (cpu_read) begin
                    addr_d    = cpu_addr;
                    prog_op_d = 1'b0;
                    state_d   = R_EN;
                end
            end
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = strobe_done ? W_HOLD : W_STROBE;
            W_HOLD:   state_d = W_VERIFY;
            W_VERIFY: begin
                if (prog_op_q) begin
                    count_d = count_q + (ADDR_WIDTH + 1)'(1);
                    err_d   = err_q | (q_true != data_q);
                end
                state_d = IDLE;
            end
            R_EN:     state_d = R_CAP;
            R_CAP: begin
                rdata_d  = q_true;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        // entering programming mode starts a fresh session
        if (prog_mode && !pm_q) begin
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            prog_op_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            pm_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            prog_op_q <= prog_op_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            count_q   <= count_d;
            err_q     <= err_d;
            pm_q      <= prog_mode;
        end
    end

    assign prog_ready  = (state_q == IDLE) && prog_mode && !rst;
    assign cpu_busy    = state_q != IDLE;
    assign cpu_rdata   = rdata_q;
    assign cpu_rvalid  = rvalid_q;
    assign prog_count  = count_q;
    assign verify_err  = err_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_we_n    = state_q != W_STROBE;
    assign mem_oe_n    = !(state_q inside {R_EN, R_CAP, W_VERIFY});
endmodule

// File: tb/tb_ram_sequencer.sv
// tb_ram_sequencer: directed scoreboard bench with an inverting RAM model and stuck-bit injection
module tb_ram_sequencer;
    import ram_sequencer_pkg::*;
    logic       clk, rst, prog_mode, prog_valid, cpu_write, cpu_read, stuck;
    logic [3:0] prog_addr, cpu_addr;
    logic [7:0] prog_data, cpu_wdata;
    logic       prog_ready, verify_err, cpu_busy, cpu_rvalid, mem_we_n, mem_oe_n;
    logic [4:0] prog_count;
    logic [7:0] cpu_rdata, mem_data, mem_q;
    logic [3:0] mem_address;
    logic       prog_ready3, verify_err3, cpu_busy3, cpu_rvalid3, mem_we_n3, mem_oe_n3;
    logic [4:0] prog_count3;
    logic [7:0] cpu_rdata3, mem_data3, mem_q3;
    logic [3:0] mem_address3;
    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    ram_sequencer #(.WE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_count(prog_count), .verify_err(verify_err),
        .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .mem_address(mem_address),
        .mem_data(mem_data), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n), .mem_q(mem_q)
    );

    ram_sequencer #(.WE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_ready(prog_ready3),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_count(prog_count3), .verify_err(verify_err3),
        .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy3), .cpu_rdata(cpu_rdata3), .cpu_rvalid(cpu_rvalid3), .mem_address(mem_address3),
        .mem_data(mem_data3), .mem_we_n(mem_we_n3), .mem_oe_n(mem_oe_n3), .mem_q(mem_q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (!mem_we_n) ram[mem_address] <= mem_data;
    assign mem_q  = mem_oe_n ? 8'hFF : ~(ram[mem_address] & (stuck ? 8'hFE : 8'hFF));
    assign mem_q3 = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("we_oe_overlap", 32'(!mem_we_n && !mem_oe_n), 0);
            check("we_oe_overlap3", 32'(!mem_we_n3 && !mem_oe_n3), 0);
        end
        if (cpu_rvalid) begin
            if (sb.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", cpu_rdata, sb.pop_front());
        end
    end

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        int n, we;
        n = 0;
        we = 0;
        while (!prog_ready && n < 20) begin tick(); n++; end
        check("pw_ready", prog_ready, 1);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        tick();
        prog_valid = 1'b0;
        n = 0;
        while (!prog_ready && n < 20) begin
            if (!mem_we_n) we++;
            n++;
            tick();
        end
        check("pw_we_low", we, 1);
        check("pw_busy_cycles", n, 4);
        check("pw_addr_hold", mem_address, a);
        check("pw_data_hold", mem_data, d);
    endtask

    task automatic cpu_rd(input logic [3:0] a, input logic [7:0] d);
        int n;
        logic [7:0] q, nd;
        q  = 8'h00;
        nd = ~d;
        sb.push_back(d);
        cpu_read = 1'b1;
        cpu_addr = a;
        tick();
        cpu_read = 1'b0;
        n = 1;
        while (!cpu_rvalid && n < 10) begin
            if (!mem_oe_n) q = mem_q;
            tick();
            n++;
        end
        check("rd_latency", n, 3);
        check("rd_mem_q", q, nd);
    endtask

    initial begin
        int n;
        logic rv;
        rst = 1'b1; prog_mode = 1'b0; prog_valid = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0; stuck = 1'b0;
        prog_addr = '0; prog_data = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) tick();
        check("rst_we_n", mem_we_n, 1);
        check("rst_oe_n", mem_oe_n, 1);
        check("rst_addr", mem_address, 0);
        check("rst_data", mem_data, 0);
        check("rst_ready", prog_ready, 0);
        check("rst_count", prog_count, 0);
        check("rst_err", verify_err, 0);
        check("rst_busy", cpu_busy, 0);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_rdata", cpu_rdata, 0);
        rst = 1'b0;
        tick();
        prog_mode = 1'b1;
        tick();
        prog_write(4'h2, 8'hAA);
        prog_write(4'h5, 8'hCC);
        check("prog_count_2", prog_count, 2);
        check("prog_err_0", verify_err, 0);
        prog_mode = 1'b0;
        tick();
        cpu_rd(4'h2, 8'hAA);
        cpu_rd(4'h5, 8'hCC);
        cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'h3C;
        tick();
        cpu_write = 1'b0; cpu_read = 1'b0;
        tick();
        check("ovl_busy", cpu_busy, 1);
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        n = 0;
        rv = 1'b0;
        while (cpu_busy && n < 20) begin
            if (cpu_rvalid) rv = 1'b1;
            tick();
            n++;
        end
        repeat (3) begin
            if (cpu_rvalid) rv = 1'b1;
            tick();
        end
        check("ovl_idle", cpu_busy, 0);
        check("ovl_no_rvalid", rv, 0);
        cpu_rd(4'h3, 8'h3C);
        stuck = 1'b1;
        prog_mode = 1'b1;
        tick();
        prog_write(4'hF, 8'h01);
        check("stuck_err", verify_err, 1);
        check("stuck_count", prog_count, 1);
        repeat (3) tick();
        check("stuck_err_sticky", verify_err, 1);
        stuck = 1'b0;
        prog_mode = 1'b0;
        tick();
        prog_mode = 1'b1;
        tick();
        check("reenter_err", verify_err, 0);
        check("reenter_count", prog_count, 0);
        for (int i = 0; i < 16; i++) prog_write(4'(i), 8'(i * 7 + 1));
        check("count_16", prog_count, 16);
        check("err_after_16", verify_err, 0);
        prog_mode = 1'b0;
        tick();
        cpu_rd(4'h0, 8'h01);
        cpu_rd(4'hF, 8'h6A);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1; prog_addr = 4'h7; prog_data = 8'h5A;
        tick();
        prog_valid = 1'b0;
        tick();
        check("s3_strobe_a", mem_we_n3, 0);
        tick();
        check("s3_strobe_b", mem_we_n3, 0);
        rst = 1'b1;
        tick();
        check("s3_rst_we_n", mem_we_n3, 1);
        check("s3_rst_oe_n", mem_oe_n3, 1);
        check("s3_rst_addr", mem_address3, 0);
        check("s3_rst_data", mem_data3, 0);
        check("s3_rst_ready", prog_ready3, 0);
        check("s3_rst_busy", cpu_busy3, 0);
        check("s3_rst_rvalid", cpu_rvalid3, 0);
        check("s3_rst_rdata", cpu_rdata3, 0);
        check("s3_rst_count", prog_count3, 0);
        check("s3_rst_err", verify_err3, 0);
        rst = 1'b0;
        repeat (2) tick();
        check("s3_count_after", prog_count3, 0);
        check("s3_ready_after", prog_ready3, 1);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_sequencer.md
Name: ram_sequencer

Overview:
- Controller for the 16x8 active-low-controlled RAM: sequences every write and read with correct setup, strobe and hold phases.
- Arbitrates RAM access between a programming port (loader, valid/ready handshake) and the CPU control-word port (RI/RO style single-cycle requests).
- Undoes the RAM's inverting read path so both requesters see true data.
- Read-back-verifies each programmed byte.

Parameters:
- ADDR_WIDTH, 4, RAM address width (16 words).
- DATA_WIDTH, 8, RAM word width.
- WE_CYCLES, 1, number of cycles write_enable is held low (1..4).
- INVERT_READ, 1, 1 = RAM returns the complement of the stored word, so the controller re-inverts it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_mode  in  1  1 = programming port owns the RAM; 0 = CPU owns it.
- prog_valid  in  1  programming byte offered.
- prog_ready  out  1  sequencer can accept a programming byte.
- prog_addr  in  ADDR_WIDTH  programming address.
- prog_data  in  DATA_WIDTH  programming data.
- prog_count  out  ADDR_WIDTH+1  completed programming writes since entering prog_mode.
- verify_err  out  1  sticky: a read-back mismatched.
- cpu_write  in  1  CPU write request (1-cycle pulse).
- cpu_read  in  1  CPU read request (1-cycle pulse).
- cpu_addr  in  ADDR_WIDTH  CPU address (MAR).
- cpu_wdata  in  DATA_WIDTH  CPU write data (bus).
- cpu_busy  out  1  sequencer not idle; CPU requests are dropped.
- cpu_rdata  out  DATA_WIDTH  true (de-inverted) read data.
- cpu_rvalid  out  1  1-cycle pulse, cpu_rdata valid.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_data  out  DATA_WIDTH  to RAM data.
- mem_we_n  out  1  to RAM write_enable (active low).
- mem_oe_n  out  1  to RAM enable (active low).
- mem_q  in  DATA_WIDTH  from RAM bus_out.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: mem_we_n=1, mem_oe_n=1, mem_address=0, mem_data=0, prog_ready=0, prog_count=0, verify_err=0, cpu_busy=0, cpu_rvalid=0, cpu_rdata=0, state=IDLE.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, W_VERIFY, R_EN, R_CAP.
- Ownership: the owner is sampled only in IDLE. A prog_mode change during a transaction takes effect on return to IDLE.
- prog_ready = IDLE & prog_mode & ~rst. A byte is accepted on valid&ready: latch the address and data, go to W_SETUP.
- CPU in IDLE with prog_mode=0:
  - cpu_write -> latch cpu_addr and cpu_wdata, go to W_SETUP.
  - cpu_read -> latch cpu_addr, go to R_EN.
  - cpu_write and cpu_read together: the write wins and the read is dropped.
- While not IDLE, cpu_busy=1 and any cpu_read or cpu_write pulse is ignored.
- W_SETUP (1 cycle): address and data driven, mem_we_n=1.
- W_STROBE (WE_CYCLES cycles, down-counter): mem_we_n=0.
- W_HOLD (1 cycle): mem_we_n=1, address and data held.
- W_VERIFY (1 cycle): mem_oe_n=0. At the edge, compare the (de-inverted) mem_q with the latched data.
  - A mismatch sets verify_err, for programming writes only; CPU writes skip the compare.
  - Then go to IDLE.
- Write occupancy is 3+WE_CYCLES cycles from acceptance to prog_ready high again (4 cycles at default).
- Read:
  - R_EN: mem_oe_n=0.
  - R_CAP: mem_oe_n stays 0 and mem_q is captured, with cpu_rdata = INVERT_READ ? ~mem_q : mem_q.
  - cpu_rvalid pulses on the cycle after R_CAP, together with the return to IDLE.
  - Read latency is 3 cycles from the request to cpu_rvalid.
- mem_we_n and mem_oe_n are never low in the same cycle. Outside R_EN, R_CAP and W_VERIFY, mem_oe_n=1, so the RAM output is high-Z.
- prog_count increments on each completed programming write and wraps modulo 32. It resets to 0 on rst and on a rising edge of prog_mode. verify_err clears on the same events.
- Reset mid-operation: the next edge forces IDLE and mem_we_n=1. A write interrupted in W_STROBE may be partial, and prog_count does not count it.
- mem_address and mem_data hold their last values in IDLE; no glitch-to-zero.

Decomposition:
- Shared package holds:
  - the state enum (IDLE..R_CAP),
  - the default ADDR_WIDTH and DATA_WIDTH constants,
  - the RAM depth constant 2**ADDR_WIDTH.
- One sub-module, ram_strobe_timer: a loadable down-counter that generates the W_STROBE duration from WE_CYCLES and reports done.
- Arbitration and the datapath latches stay in the top-level module.

Test Plan:
- prog_mode=1; write 0xAA to addr 0x2 and 0xCC to addr 0x5 via handshake -> each write shows mem_we_n low exactly 1 cycle, prog_ready low 4 cycles, prog_count=2, verify_err=0.
- prog_mode=0; cpu_read addr 0x2, then addr 0x5 -> cpu_rvalid 3 cycles after each request with cpu_rdata=0xAA then 0xCC. mem_q shows 0x55 and 0x33, i.e. the inverted words.
- Model the RAM with a stuck bit (bit0 forced 0 on readback); program 0x01 to addr 0xF -> verify_err=1 and stays 1; toggle prog_mode 0->1 -> verify_err=0, prog_count=0.
- Assert cpu_write and cpu_read in the same cycle (addr 0x3, data 0x3C), then issue cpu_read 2 cycles later -> the write completes, the overlapping read is dropped, no cpu_rvalid. A fresh read of 0x3 returns 0x3C.
- Assert rst during W_STROBE with WE_CYCLES=3 -> on the next edge mem_we_n=1, all outputs at reset values, prog_count unchanged at 0.
- Across all tests, assert mem_we_n and mem_oe_n are never both 0, and that 16 sequential programming writes take prog_count to 16.
